// File: rtl/stack_game_sequencer.sv
// Stacker game sequencer: debounced start/drop button, level-dependent move ticks,
// drop handshake with the block datapath, win/lose hold. Define STACK_SPEEDUP_EN for per-row speedup.
module stack_game_sequencer #(
   parameter int unsigned TICK_DIV_BASE = 5_000_000,
   parameter int unsigned TICK_DIV_STEP = 400_000,
   parameter int unsigned TICK_DIV_MIN  = 1_000_000,
   parameter int unsigned DEBOUNCE_CYC  = 500_000,
   parameter int unsigned MAX_ROWS      = 10,
   parameter int unsigned MIN_WIDTH     = 10,
   parameter int unsigned RESULT_HOLD   = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   input  logic [9:0] drop_width,
   input  logic       drop_ack,
   output logic       move_tick,
   output logic       drop_req,
   output logic       clear_stack,
   output logic [3:0] row,
   output logic       playing,
   output logic       win,
   output logic       lose
);

   typedef enum logic [2:0] {
      S_IDLE, S_PLAY, S_DROP, S_EVAL, S_WIN, S_LOSE
   } state_t;

   localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYC - 1);
   localparam logic [31:0] HOLD_LAST = 32'(RESULT_HOLD - 1);
   localparam logic [31:0] MIN_W     = 32'(MIN_WIDTH);
   localparam logic [3:0]  LAST_ROW  = 4'(MAX_ROWS - 1);

   state_t      state, state_n;
   logic        btn_s1, btn_s2, db_level, db_prev, press;
   logic [31:0] db_cnt;
   logic [31:0] tick_cnt, tick_n, hold_cnt, hold_n, period;
   logic [3:0]  row_n;
   logic [9:0]  width_q, width_n;

`ifdef STACK_SPEEDUP_EN
   // Saturating decrement: a large row*step clamps to the floor instead of wrapping.
   function automatic logic [31:0] sat_period(input logic [3:0] r);
      logic [35:0] dec;
      logic [31:0] diff;
      dec = 36'(r) * 36'(TICK_DIV_STEP);
      if (dec >= 36'(TICK_DIV_BASE))
         diff = '0;
      else
         diff = TICK_DIV_BASE - dec[31:0];
      return (diff < TICK_DIV_MIN) ? TICK_DIV_MIN : diff;
   endfunction

   assign period = sat_period(row);
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = TICK_DIV_STEP ^ TICK_DIV_MIN;
   assign period     = TICK_DIV_BASE;
`endif

   // Button: two-flop synchroniser, then the level only moves after DEBOUNCE_CYC differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1   <= 1'b0;
         btn_s2   <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_s1  <= btn_in;
         btn_s2  <= btn_s1;
         db_prev <= db_level;
         if (btn_s2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt >= DB_LAST) begin
            db_level <= btn_s2;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + 32'd1;
         end
      end
   end

   assign press = db_level & ~db_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         hold_cnt <= '0;
         row      <= '0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         hold_cnt <= hold_n;
         row      <= row_n;
      end
   end

   // Captured width is only read in EVAL, after a capture, so it needs no reset.
   always_ff @(posedge clk) begin
      width_q <= width_n;
   end

   always_comb begin
      state_n     = state;
      tick_n      = tick_cnt;
      hold_n      = hold_cnt;
      row_n       = row;
      width_n     = width_q;
      move_tick   = 1'b0;
      drop_req    = 1'b0;
      clear_stack = 1'b0;
      playing     = (state == S_PLAY) || (state == S_DROP) || (state == S_EVAL);
      win         = (state == S_WIN);
      lose        = (state == S_LOSE);
      case (state)
         S_IDLE: begin
            if (press) begin
               clear_stack = 1'b1;
               row_n       = '0;
               tick_n      = '0;
               state_n     = S_PLAY;
            end
         end
         S_PLAY: begin
            // The tick still fires when a press lands on the wrap cycle.
            if (tick_cnt >= period - 32'd1) begin
               move_tick = 1'b1;
               tick_n    = '0;
            end else begin
               tick_n = tick_cnt + 32'd1;
            end
            if (press)
               state_n = S_DROP;
         end
         S_DROP: begin
            drop_req = 1'b1;
            if (drop_ack) begin
               width_n = drop_width;
               state_n = S_EVAL;
            end
         end
         S_EVAL: begin
            if ({22'd0, width_q} < MIN_W) begin
               hold_n  = '0;
               state_n = S_LOSE;
            end else if (row == LAST_ROW) begin
               hold_n  = '0;
               state_n = S_WIN;
            end else begin
               row_n   = row + 4'd1;
               tick_n  = '0;
               state_n = S_PLAY;
            end
         end
         S_WIN, S_LOSE: begin
            if (press || (hold_cnt >= HOLD_LAST)) begin
               hold_n  = '0;
               state_n = S_IDLE;
            end else begin
               hold_n = hold_cnt + 32'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_stack_game_sequencer.sv
// Scoreboard bench for stack_game_sequencer: a game-level model predicts output events with
// cycle stamps; a monitor matches every observed output event against the expected queue.
module tb_stack_game_sequencer;

   localparam int BASE  = 8;
   localparam int STEP  = 2;
   localparam int MINP  = 4;
   localparam int DEB   = 4;
   localparam int ROWS  = 3;
   localparam int MINW  = 10;
   localparam int HOLD  = 16;
   localparam int LAT   = 2 + DEB;   // btn rise (cycle n) -> press seen in cycle n+LAT

   localparam int EV_CLEAR    = 0;
   localparam int EV_TICK     = 1;
   localparam int EV_PLAY_ON  = 2;
   localparam int EV_PLAY_OFF = 3;
   localparam int EV_DREQ_ON  = 4;
   localparam int EV_DREQ_OFF = 5;
   localparam int EV_WIN_ON   = 6;
   localparam int EV_WIN_OFF  = 7;
   localparam int EV_LOSE_ON  = 8;
   localparam int EV_LOSE_OFF = 9;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_in = 1'b0;
   logic [9:0] drop_width = '0;
   logic       drop_ack = 1'b0;
   logic       move_tick, drop_req, clear_stack, playing, win, lose;
   logic [3:0] row;

   stack_game_sequencer #(
      .TICK_DIV_BASE(BASE), .TICK_DIV_STEP(STEP), .TICK_DIV_MIN(MINP),
      .DEBOUNCE_CYC(DEB), .MAX_ROWS(ROWS), .MIN_WIDTH(MINW), .RESULT_HOLD(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .drop_width(drop_width), .drop_ack(drop_ack),
      .move_tick(move_tick), .drop_req(drop_req), .clear_stack(clear_stack), .row(row),
      .playing(playing), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int kind;
      int r;
   } ev_t;

   ev_t exp_q[$];
   int  n_total = 0;
   int  n_pass  = 0;
   bit  btn_hi[int];
   int  btn_free = 0;
   int  m_row = 0;
   int  m_s = 0;     // first PLAY cycle of the current row
   int  m_a = 0;     // cycle in which the last real ack was presented

   function automatic string ev_name(input int k);
      case (k)
         EV_CLEAR:    return "clear_stack";
         EV_TICK:     return "move_tick";
         EV_PLAY_ON:  return "playing_rise";
         EV_PLAY_OFF: return "playing_fall";
         EV_DREQ_ON:  return "drop_req_rise";
         EV_DREQ_OFF: return "drop_req_fall";
         EV_WIN_ON:   return "win_rise";
         EV_WIN_OFF:  return "win_fall";
         EV_LOSE_ON:  return "lose_rise";
         default:     return "lose_fall";
      endcase
   endfunction

   function automatic int period_of(input int r);
`ifdef STACK_SPEEDUP_EN
      int d;
      d = BASE - r * STEP;
      return (d < MINP) ? MINP : d;
`else
      return BASE + 0 * r;
`endif
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int rnd(input int lo, input int hi);
      return lo + int'($urandom_range(0, hi - lo));
   endfunction

   task automatic push_ev(input int c, input int kind, input int r);
      ev_t e;
      int  i;
      e.c = c; e.kind = kind; e.r = r;
      i = exp_q.size();
      while (i > 0 && (exp_q[i-1].c > c || (exp_q[i-1].c == c && exp_q[i-1].kind > kind)))
         i--;
      exp_q.insert(i, e);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sched_btn(input int on, input int len);
      for (int i = on; i < on + len; i++) btn_hi[i] = 1'b1;
      btn_free = on + len + 6;
   endtask

   function automatic int earliest_press();
      return imax(cyc + 1, btn_free) + LAT;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_move_tick"}, int'(move_tick), 0);
      check({tag, "_drop_req"}, int'(drop_req), 0);
      check({tag, "_clear_stack"}, int'(clear_stack), 0);
      check({tag, "_row"}, int'(row), 0);
      check({tag, "_playing"}, int'(playing), 0);
      check({tag, "_win"}, int'(win), 0);
      check({tag, "_lose"}, int'(lose), 0);
   endtask

   // Button driver: windows are scheduled ahead of time by the stimulus.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         btn_in = btn_hi.exists(cyc);
      end
   end

   // Monitor: every output event must match the head of the expected queue.
   initial begin
      int obs[10];
      bit pp, pd, pw, pl;
      pp = 0; pd = 0; pw = 0; pl = 0;
      forever begin
         @(negedge clk);
         obs[EV_CLEAR]    = int'(clear_stack === 1'b1);
         obs[EV_TICK]     = int'(move_tick === 1'b1);
         obs[EV_PLAY_ON]  = int'(playing === 1'b1 && !pp);
         obs[EV_PLAY_OFF] = int'(playing !== 1'b1 && pp);
         obs[EV_DREQ_ON]  = int'(drop_req === 1'b1 && !pd);
         obs[EV_DREQ_OFF] = int'(drop_req !== 1'b1 && pd);
         obs[EV_WIN_ON]   = int'(win === 1'b1 && !pw);
         obs[EV_WIN_OFF]  = int'(win !== 1'b1 && pw);
         obs[EV_LOSE_ON]  = int'(lose === 1'b1 && !pl);
         obs[EV_LOSE_OFF] = int'(lose !== 1'b1 && pl);
         pp = (playing === 1'b1); pd = (drop_req === 1'b1);
         pw = (win === 1'b1);     pl = (lose === 1'b1);
         while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            n_total++;
            $display("FAIL missed_%s: not seen by cycle %0d, required at cycle %0d",
                     ev_name(exp_q[0].kind), cyc, exp_q[0].c);
            void'(exp_q.pop_front());
         end
         for (int k = 0; k < 10; k++) begin
            if (obs[k] != 0) begin
               n_total++;
               if (exp_q.size() > 0 && exp_q[0].c == cyc && exp_q[0].kind == k) begin
                  if (int'(row) == exp_q[0].r) n_pass++;
                  else $display("FAIL row_at_%s cycle %0d: row %0d, expected %0d",
                                ev_name(k), cyc, row, exp_q[0].r);
                  void'(exp_q.pop_front());
               end else begin
                  $display("FAIL unexpected_%s at cycle %0d: event seen, expected none", ev_name(k), cyc);
               end
            end
         end
      end
   end

   task automatic start_game(input int hold);
      int q;
      q = earliest_press() + rnd(0, 3);
      sched_btn(q - LAT, hold);
      push_ev(q, EV_CLEAR, m_row);
      push_ev(q + 1, EV_PLAY_ON, 0);
      m_row = 0;
      m_s   = q + 1;
   endtask

   // Schedule a press in PLAY at cycle p; ticks up to and including p, then drop_req.
   task automatic arm_press(input int hold, output int p);
      int per;
      per = period_of(m_row);
      p = earliest_press() + rnd(0, 2 * per);
      sched_btn(p - LAT, hold);
      for (int t = m_s + per - 1; t <= p; t += per) push_ev(t, EV_TICK, m_row);
      push_ev(p + 1, EV_DREQ_ON, m_row);
   endtask

   task automatic do_drop(input int w, input bit drop_press, output int res);
      int p, a, pd, sx, ah;
      arm_press(drop_press ? 4 : rnd(4, 8), p);
      if (drop_press) begin
         a  = p + 10 + rnd(0, 3);
         pd = rnd(p + 10, a);
         sched_btn(pd - LAT, 4);
      end else begin
         a = p + 1 + rnd(0, 6);
      end
      push_ev(a + 1, EV_DREQ_OFF, m_row);
      sx = rnd(imax(cyc + 1, m_s), p);
      wait_until(sx);
      drop_ack = 1'b1; drop_width = 10'(rnd(0, 1023));
      wait_until(sx + 1);
      drop_ack = 1'b0;
      wait_until(a);
      drop_ack = 1'b1; drop_width = 10'(w);
      m_a = a;
      if (w < MINW) begin
         push_ev(a + 2, EV_PLAY_OFF, m_row);
         push_ev(a + 2, EV_LOSE_ON, m_row);
         res = 2;
      end else if (m_row == ROWS - 1) begin
         push_ev(a + 2, EV_PLAY_OFF, m_row);
         push_ev(a + 2, EV_WIN_ON, m_row);
         res = 1;
      end else begin
         m_row = m_row + 1;
         m_s   = a + 2;
         res   = 0;
      end
      ah = rnd(1, 3);
      wait_until(a + ah);
      drop_ack = 1'b0; drop_width = 10'(rnd(0, 1023));
   endtask

   task automatic finish_result(input int res, input bit early);
      int off, q;
      off = m_a + 2 + HOLD;
      if (early) begin
         q = earliest_press();
         if (q <= m_a + 1 + HOLD) begin
            q = rnd(q, m_a + 1 + HOLD);
            sched_btn(q - LAT, 4);
            off = q + 1;
         end
      end
      push_ev(off, (res == 1) ? EV_WIN_OFF : EV_LOSE_OFF, m_row);
      wait_until(off);
   endtask

   // mode 0: three wide drops -> win, auto return; 1: width 9 -> lose, early press;
   // 3: width 5 -> lose, auto return; otherwise random.
   task automatic run_game(input int mode);
      int res, w;
      bit dp;
      start_game(mode == 0 ? 10 : rnd(4, 8));
      res = 0;
      for (int d = 0; d < ROWS && res == 0; d++) begin
         dp = 0;
         case (mode)
            0: w = 40;
            1: w = 9;
            3: w = 5;
            default: begin
               if (rnd(0, 99) < 12) w = rnd(0, 9);
               else if (rnd(0, 9) == 0) w = 10;
               else w = rnd(10, 1023);
               dp = (rnd(0, 3) == 0);
            end
         endcase
         do_drop(w, dp, res);
      end
      finish_result(res, (mode == 1) ? 1'b1 : ((mode == 0 || mode == 3) ? 1'b0 : 1'(rnd(0, 1))));
   endtask

   task automatic reset_mid_drop();
      int res, p;
      start_game(5);
      do_drop(40, 1'b0, res);
      arm_press(5, p);
      wait_until(p + 3);
      push_ev(p + 3, EV_DREQ_OFF, 0);
      push_ev(p + 3, EV_PLAY_OFF, 0);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      wait_until(p + 5);
      rst = 1'b0;
      m_row = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      sched_btn(cyc + 2, 2);
      wait_until(cyc + 16);
      check("glitch_idle_playing", int'(playing), 0);
      check("glitch_idle_row", int'(row), 0);
      run_game(0);
      run_game(1);
      for (int g = 0; g < 6; g++) run_game(2);
      reset_mid_drop();
      run_game(3);
      wait_until(cyc + 12);
      while (exp_q.size() > 0) begin
         n_total++;
         $display("FAIL pending_%s: never seen, required at cycle %0d", ev_name(exp_q[0].kind), exp_q[0].c);
         void'(exp_q.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
